uart_tx_sched: RTL and testbench

Transmit scheduler in front of the UART transmitter core. It arbitrates between two word-oriented requesters: port 0 carries command responses (ID and metadata), port 1 carries the sample readout stream. It serializes each granted word, LSB byte first, into single-byte strobes for the transmitter, and paces them with the transmitter's busy flag. No byte of one word is interleaved with bytes of another.

---
 rtl/uart_tx_sched.sv | 162 ++++++++++++++++
 tb/tb_uart_tx_sched.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// -----------------------------------------------------------------------------
// uart_tx_sched
//
// Transmit scheduler in front of the UART transmitter core. Two word-oriented
// requesters share one byte-wide transmitter: port 0 carries command
// responses, port 1 carries the sample readout stream. A granted 32-bit word
// is sent LSB byte first as single-cycle strobes, paced by the transmitter's
// busy flag. A word is always finished before the next one is granted.
//
// Ports:
//   clk_i      in   1   system clock, rising edge
//   rst_i      in   1   synchronous active-high reset
//   req_i      in   2   per-port request, held with data/len until ack
//   data0_i    in  32   port 0 word, byte 0 = bits [7:0]
//   data1_i    in  32   port 1 word, byte 0 = bits [7:0]
//   len0_i     in   2   port 0 byte count minus 1
//   len1_i     in   2   port 1 byte count minus 1
//   ack_o      out  2   one-cycle pulse: word captured for that port
//   tx_data_o  out  8   byte to the transmitter, valid with tx_stb_o
//   tx_stb_o   out  1   one-cycle transmit strobe
//   tx_bsy_i   in   1   transmitter busy (rises the cycle after a strobe)
//   busy_o     out  1   scheduler not idle
//   grant_o    out  1   port being serialized, valid while busy_o
// -----------------------------------------------------------------------------
module uart_tx_sched (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  req_i,
    input  logic [31:0] data0_i,
    input  logic [31:0] data1_i,
    input  logic [1:0]  len0_i,
    input  logic [1:0]  len1_i,
    output logic [1:0]  ack_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_stb_o,
    input  logic        tx_bsy_i,
    output logic        busy_o,
    output logic        grant_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_GUARD = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [31:0] r_shift;
    logic [1:0]  r_cnt;
    logic        r_last;
    logic [1:0]  r_ack;
    logic [7:0]  r_tx_data;
    logic        r_tx_stb;
    logic        r_busy;
    logic        r_grant;

    logic        w_gnt_idx;
    logic        w_take;
    logic        w_strobe;
    logic        w_advance;

    // Round-robin pick. With a single requester, req_i[1] already names it;
    // on a tie the port not granted last wins.
    always_comb begin
        if (req_i == 2'b11) begin
            w_gnt_idx = ~r_last;
        end else begin
            w_gnt_idx = req_i[1];
        end
    end

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement leaves one unassigned and infers a latch.
    always_comb begin
        w_state_next = r_state;
        w_take       = 1'b0;
        w_strobe     = 1'b0;
        w_advance    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|req_i) begin
                    w_take       = 1'b1;
                    w_state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                if (!tx_bsy_i) begin
                    w_strobe     = 1'b1;
                    w_state_next = ST_GUARD;
                end
            end
            ST_GUARD: begin
                // The transmitter raises busy one cycle after the strobe; this
                // state lets that rise arrive before SEND looks at it again.
                if (r_cnt == 2'd0) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_advance    = 1'b1;
                    w_state_next = ST_SEND;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_shift   <= 32'h0;
            r_cnt     <= 2'd0;
            r_last    <= 1'b1;      // port 0 wins the first tie
            r_ack     <= 2'b00;
            r_tx_data <= 8'h00;
            r_tx_stb  <= 1'b0;
            r_busy    <= 1'b0;
            r_grant   <= 1'b0;
        end else begin
            r_ack    <= 2'b00;
            r_tx_stb <= w_strobe;
            // Registered from the next state so busy_o tracks "not IDLE"
            // exactly, without a combinational path to the output.
            r_busy   <= (w_state_next != ST_IDLE);

            if (w_take) begin
                r_shift <= w_gnt_idx ? data1_i : data0_i;
                r_cnt   <= w_gnt_idx ? len1_i  : len0_i;
                r_last  <= w_gnt_idx;
                r_grant <= w_gnt_idx;
                r_ack   <= w_gnt_idx ? 2'b10 : 2'b01;
            end

            if (w_strobe) begin
                r_tx_data <= r_shift[7:0];
            end

            if (w_advance) begin
                r_shift <= {8'h00, r_shift[31:8]};
                r_cnt   <= r_cnt - 2'd1;
            end
        end
    end

    assign ack_o     = r_ack;
    assign tx_data_o = r_tx_data;
    assign tx_stb_o  = r_tx_stb;
    assign busy_o    = r_busy;
    assign grant_o   = r_grant;

endmodule

// File: tb/tb_uart_tx_sched.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_sched
//
// Self-checking bench for uart_tx_sched. A small transmitter model raises
// tx_bsy_i the cycle after each strobe for a fixed number of cycles; a monitor
// logs strobes and acks with their cycle numbers. Single-word transfers are
// driven from a vector table; round-robin, stalled busy, mid-word reset and
// back-to-back words are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_uart_tx_sched;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [1:0]  req_i;
    logic [31:0] data0_i;
    logic [31:0] data1_i;
    logic [1:0]  len0_i;
    logic [1:0]  len1_i;
    logic [1:0]  ack_o;
    logic [7:0]  tx_data_o;
    logic        tx_stb_o;
    logic        tx_bsy_i;
    logic        busy_o;
    logic        grant_o;

    uart_tx_sched dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (req_i),
        .data0_i   (data0_i),
        .data1_i   (data1_i),
        .len0_i    (len0_i),
        .len1_i    (len1_i),
        .ack_o     (ack_o),
        .tx_data_o (tx_data_o),
        .tx_stb_o  (tx_stb_o),
        .tx_bsy_i  (tx_bsy_i),
        .busy_o    (busy_o),
        .grant_o   (grant_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk_i) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- transmitter model and monitor ----------------
    localparam int BUSY_LEN = 10;

    typedef struct {
        int         cyc;
        logic       g;
        logic [7:0] d;
    } stb_rec_t;

    typedef struct {
        int         cyc;
        logic [1:0] v;
    } ack_rec_t;

    stb_rec_t stb_q[$];
    ack_rec_t ack_q[$];
    logic     force_bsy = 1'b0;
    int       bsy_cnt   = 0;
    logic     stb_prev  = 1'b0;
    logic     busy_prev = 1'b0;
    int       fall_cyc  = -1;

    assign tx_bsy_i = force_bsy | (bsy_cnt > 0);

    always @(negedge clk_i) begin
        if (tx_stb_o) begin
            check("stb_while_bsy", 32'(tx_bsy_i), 32'd0);
            check("stb_consecutive", 32'(stb_prev), 32'd0);
            check("busy_during_stb", 32'(busy_o), 32'd1);
            stb_q.push_back('{cyc, grant_o, tx_data_o});
        end
        if (ack_o != 2'b00) ack_q.push_back('{cyc, ack_o});
        if (busy_prev && !busy_o) fall_cyc = cyc;
        busy_prev = busy_o;
        // Busy rises in the cycle after a strobe and stays up BUSY_LEN cycles.
        if (stb_prev) bsy_cnt = BUSY_LEN;
        else if (bsy_cnt > 0) bsy_cnt--;
        stb_prev = tx_stb_o;
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic look();
        @(negedge clk_i);
        #1;
    endtask

    task automatic clear_logs();
        stb_q.delete();
        ack_q.delete();
        fall_cyc = -1;
    endtask

    task automatic request(input logic p, input logic [31:0] d, input logic [1:0] l);
        bit got;
        got = 1'b0;
        tick();
        if (p) begin
            data1_i = d;
            len1_i  = l;
        end else begin
            data0_i = d;
            len0_i  = l;
        end
        req_i[p] = 1'b1;
        for (int i = 0; i < 300 && !got; i++) begin
            look();
            if (ack_o[p]) got = 1'b1;
        end
        check("ack_seen", 32'(got), 32'd1);
        tick();
        req_i[p] = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            look();
            if (!busy_o && !tx_bsy_i) break;
        end
        check("wait_done_busy", 32'(busy_o), 32'd0);
    endtask

    task automatic do_reset();
        tick();
        rst_i = 1'b1;
        req_i = 2'b00;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic            p;
        logic [31:0]     data;
        logic [1:0]      len;
        logic [1:0]      exp_ack;
        int              exp_n;
        logic [3:0][7:0] exp_seq;   // exp_seq[0] is the first byte sent
    } vec_t;

    vec_t vecs[4];

    logic [7:0] rr_bytes[8] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04};
    logic       rr_grant[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [1:0] rr_acks[4]  = '{2'b01, 2'b10, 2'b01, 2'b10};

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rel_cyc;

        vecs[0] = '{p: 1'b0, data: 32'hDDCCBBAA, len: 2'd3, exp_ack: 2'b01, exp_n: 4,
                    exp_seq: {8'hDD, 8'hCC, 8'hBB, 8'hAA}};
        vecs[1] = '{p: 1'b1, data: 32'h12345678, len: 2'd0, exp_ack: 2'b10, exp_n: 1,
                    exp_seq: {8'h00, 8'h00, 8'h00, 8'h78}};
        vecs[2] = '{p: 1'b1, data: 32'hCAFEF00D, len: 2'd2, exp_ack: 2'b10, exp_n: 3,
                    exp_seq: {8'h00, 8'hFE, 8'hF0, 8'h0D}};
        vecs[3] = '{p: 1'b0, data: 32'h11223344, len: 2'd1, exp_ack: 2'b01, exp_n: 2,
                    exp_seq: {8'h00, 8'h00, 8'h33, 8'h44}};

        rst_i   = 1'b1;
        req_i   = 2'b00;
        data0_i = 32'h0;
        data1_i = 32'h0;
        len0_i  = 2'd0;
        len1_i  = 2'd0;

        // ---- reset values ----
        repeat (3) tick();
        look();
        check("rst_ack", 32'(ack_o), 32'd0);
        check("rst_stb", 32'(tx_stb_o), 32'd0);
        check("rst_data", 32'(tx_data_o), 32'h00);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_grant", 32'(grant_o), 32'd0);
        tick();
        rst_i = 1'b0;

        // ---- table-driven single words ----
        for (int v = 0; v < 4; v++) begin
            clear_logs();
            request(vecs[v].p, vecs[v].data, vecs[v].len);
            wait_done(400);
            check("vec_ack_count", 32'(ack_q.size()), 32'd1);
            if (ack_q.size() > 0) check("vec_ack_port", 32'(ack_q[0].v), 32'(vecs[v].exp_ack));
            check("vec_stb_count", 32'(stb_q.size()), 32'(vecs[v].exp_n));
            for (int i = 0; i < stb_q.size() && i < vecs[v].exp_n; i++) begin
                check("vec_byte", 32'(stb_q[i].d), 32'(vecs[v].exp_seq[i]));
                check("vec_grant", 32'(stb_q[i].g), 32'(vecs[v].p));
                // First busy-low cycle after the transmitter's busy window.
                if (i > 0) check("vec_stb_gap", 32'(stb_q[i].cyc - stb_q[i-1].cyc), 32'(BUSY_LEN + 2));
            end
            if (ack_q.size() > 0 && stb_q.size() > 0) begin
                check("vec_ack_to_stb", 32'(stb_q[0].cyc - ack_q[0].cyc), 32'd1);
                check("vec_busy_fall", 32'(fall_cyc - stb_q[stb_q.size()-1].cyc), 32'd1);
            end
        end

        // ---- round-robin with both ports requesting continuously ----
        do_reset();
        clear_logs();
        tick();
        data0_i = 32'h0000_0201;
        len0_i  = 2'd1;
        data1_i = 32'h0000_0403;
        len1_i  = 2'd1;
        req_i   = 2'b11;
        for (int i = 0; i < 2000 && ack_q.size() < 4; i++) look();
        tick();
        req_i = 2'b00;
        wait_done(400);
        check("rr_ack_count", 32'(ack_q.size()), 32'd4);
        for (int i = 0; i < ack_q.size() && i < 4; i++) check("rr_ack", 32'(ack_q[i].v), 32'(rr_acks[i]));
        check("rr_stb_count", 32'(stb_q.size()), 32'd8);
        for (int i = 0; i < stb_q.size() && i < 8; i++) begin
            check("rr_byte", 32'(stb_q[i].d), 32'(rr_bytes[i]));
            check("rr_grant", 32'(stb_q[i].g), 32'(rr_grant[i]));
        end

        // ---- transmitter held busy for 50 cycles ----
        clear_logs();
        tick();
        force_bsy = 1'b1;
        request(1'b0, 32'h0000_005A, 2'd0);
        repeat (50) tick();
        check("stall_no_stb", 32'(stb_q.size()), 32'd0);
        check("stall_busy", 32'(busy_o), 32'd1);
        tick();
        force_bsy = 1'b0;
        rel_cyc   = cyc;
        wait_done(400);
        check("stall_stb_count", 32'(stb_q.size()), 32'd1);
        if (stb_q.size() > 0) begin
            check("stall_byte", 32'(stb_q[0].d), 32'h5A);
            check("stall_stb_cycle", 32'(stb_q[0].cyc - rel_cyc), 32'd1);
        end

        // ---- reset after the 2nd byte of a 4-byte word ----
        clear_logs();
        request(1'b0, 32'h4433_2211, 2'd3);
        for (int i = 0; i < 400 && stb_q.size() < 2; i++) look();
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        look();
        check("midrst_ack", 32'(ack_o), 32'd0);
        check("midrst_stb", 32'(tx_stb_o), 32'd0);
        check("midrst_data", 32'(tx_data_o), 32'h00);
        check("midrst_busy", 32'(busy_o), 32'd0);
        check("midrst_grant", 32'(grant_o), 32'd0);
        repeat (40) look();
        check("midrst_stb_count", 32'(stb_q.size()), 32'd2);
        check("midrst_ack_count", 32'(ack_q.size()), 32'd1);
        clear_logs();
        request(1'b0, 32'h0000_00EE, 2'd0);
        wait_done(400);
        check("post_rst_count", 32'(stb_q.size()), 32'd1);
        if (stb_q.size() > 0) check("post_rst_byte", 32'(stb_q[0].d), 32'hEE);

        // ---- back-to-back words on port 1 ----
        clear_logs();
        tick();
        data1_i  = 32'h0000_BBAA;
        len1_i   = 2'd1;
        req_i[1] = 1'b1;
        for (int i = 0; i < 300 && ack_q.size() < 1; i++) look();
        tick();
        data1_i = 32'h0000_00CC;
        len1_i  = 2'd0;
        for (int i = 0; i < 300 && ack_q.size() < 2; i++) look();
        tick();
        req_i[1] = 1'b0;
        wait_done(400);
        check("b2b_ack_count", 32'(ack_q.size()), 32'd2);
        check("b2b_stb_count", 32'(stb_q.size()), 32'd3);
        if (stb_q.size() == 3) begin
            check("b2b_byte0", 32'(stb_q[0].d), 32'hAA);
            check("b2b_byte1", 32'(stb_q[1].d), 32'hBB);
            check("b2b_byte2", 32'(stb_q[2].d), 32'hCC);
        end
        // Last strobe cycle is GUARD, then one IDLE cycle, then the ack.
        if (ack_q.size() == 2 && stb_q.size() >= 2) begin
            check("b2b_ack_gap", 32'(ack_q[1].cyc - stb_q[1].cyc), 32'd2);
            check("b2b_ack_port", 32'(ack_q[1].v), 32'(2'b10));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
